// File: rtl/hex_entry_pkg.sv
// Shared constants for the hex entry bank: button indices, segment codes
// and a small helper for the active-low 7-segment lookup.
package hex_entry_pkg;

   // Button bit positions inside btn_n / push vectors
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_SET   = 2;

   // Active-low segment codes, bit order gfedcba
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;

   // Hex digit -> active-low segments; index 0 is the rightmost entry
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Cursor movement resolved from one cycle of button pushes
   typedef enum logic [1:0] {
      MOVE_NONE  = 2'd0,
      MOVE_LEFT  = 2'd1,
      MOVE_RIGHT = 2'd2
   } move_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      return SEG_LUT[hex];
   endfunction

endpackage

// File: rtl/hex_entry_bank_seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder (gfedcba).
module seg7_decode
   import hex_entry_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   // Pure table lookup, no state
   always_comb begin
      seg_n = hex_to_seg(hex);
   end

endmodule

// File: rtl/hex_entry_bank.sv
// Keypad-style hex editor for NUM_REGS registers of DATA_W bits. Three
// buttons move a cursor and write nibbles; the core may load whole
// registers. The selected page is shown on DIGITS active-low displays
// with the cursor digit blinking.
module hex_entry_bank
   import hex_entry_pkg::*;
#(
   parameter int DATA_W   = 128,
   parameter int DIGITS   = 8,
   parameter int NUM_REGS = 2,
   parameter int BLINK_W  = 24,
   localparam int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int PAGES     = DATA_W / (4 * DIGITS),
   localparam int PAGE_W    = (PAGES > 1) ? $clog2(PAGES) : 1
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   btn_n,
   input  logic [3:0]                   nibble_in,
   input  logic [SEL_W-1:0]             reg_sel,
   input  logic [PAGE_W-1:0]            page,
   input  logic                         ld_valid,
   input  logic [SEL_W-1:0]             ld_sel,
   input  logic [DATA_W-1:0]            ld_data,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic [7*DIGITS-1:0]          seg_n,
   output logic [DIGITS-1:0]            cursor_led,
   output logic                         wr_pulse
);

   localparam int CUR_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NIB_W     = (DATA_W > 4) ? $clog2(DATA_W / 4) : 1;
   localparam int LSB_W     = NIB_W + 2;
   localparam int PAGE_BITS = 4 * DIGITS;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [2:0]                        s1_q, s1_d;
   logic [2:0]                        s2_q, s2_d;
   logic [2:0]                        s3_q, s3_d;
   logic [1:0]                        vld_q, vld_d;
   logic [2:0]                        arm_q, arm_d;
   logic [CUR_W-1:0]                  cursor_q, cursor_d;
   logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
   logic [BLINK_W-1:0]                blink_q, blink_d;
   logic                              wr_pulse_q, wr_pulse_d;
   logic [DIGITS-1:0][6:0]            seg_n_q, seg_n_d;
   logic [DIGITS-1:0]                 cursor_led_q, cursor_led_d;

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic [2:0]               push;
   move_e                    move;
   logic                     page_ok;
   logic                     reg_ok;
   logic                     ld_ok;
   logic                     set_ok;
   logic [NIB_W-1:0]         set_idx;
   logic [LSB_W-1:0]         set_lsb;
   logic [PAGE_W-1:0]        pg_idx;
   logic [LSB_W-1:0]         pg_lsb;
   logic [DATA_W-1:0]        sel_reg;
   logic [PAGE_BITS-1:0]     page_word;
   logic [DIGITS-1:0][6:0]   dec_seg;

   // Synchroniser chain, post-reset qualification and falling-edge detect.
   // vld_q marks when s2 holds a genuinely sampled level rather than the
   // reset value; a button only arms once it has been seen released, so a
   // press held through reset never fires.
   always_comb begin
      s1_d  = btn_n;
      s2_d  = s1_q;
      s3_d  = s2_q;
      vld_d = {vld_q[0], 1'b1};
      arm_d = arm_q | ({3{vld_q[1]}} & s2_q);
      push  = arm_q & s3_q & ~s2_q;
   end

   // Resolve cursor movement: set freezes the cursor, opposing moves cancel
   always_comb begin
      move = MOVE_NONE;
      if (!push[BTN_SET]) begin
         if (push[BTN_LEFT] && !push[BTN_RIGHT]) begin
            move = MOVE_LEFT;
         end else if (push[BTN_RIGHT] && !push[BTN_LEFT]) begin
            move = MOVE_RIGHT;
         end
      end
   end

   // Cursor counter, modulo DIGITS in both directions
   always_comb begin
      cursor_d = cursor_q;
      case (move)
         MOVE_LEFT: begin
            cursor_d = (cursor_q == CUR_W'(DIGITS - 1)) ? '0 : cursor_q + CUR_W'(1);
         end
         MOVE_RIGHT: begin
            cursor_d = (cursor_q == '0) ? CUR_W'(DIGITS - 1) : cursor_q - CUR_W'(1);
         end
         default: ;
      endcase
   end

   // Write arbitration: a load beats a set to the same register,
   // writes to different registers both land in the same cycle
   always_comb begin
      page_ok = (32'(page) < PAGES);
      reg_ok  = (32'(reg_sel) < NUM_REGS);
      ld_ok   = ld_valid && (32'(ld_sel) < NUM_REGS);
      set_ok  = push[BTN_SET] && page_ok && reg_ok;
      set_idx = NIB_W'(32'(page) * DIGITS + 32'(cursor_q));
      set_lsb = {set_idx, 2'b00};
      regs_d  = regs_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (ld_ok && (ld_sel == SEL_W'(r))) begin
            regs_d[r] = ld_data;
         end else if (set_ok && (reg_sel == SEL_W'(r))) begin
            regs_d[r][set_lsb +: 4] = nibble_in;
         end
      end
      wr_pulse_d = ld_ok | set_ok;
   end

   // Free-running blink counter; its MSB is the blink phase
   always_comb begin
      blink_d = blink_q + BLINK_W'(1);
   end

   // Select the visible page of the edited register
   always_comb begin
      sel_reg   = reg_ok ? regs_q[reg_sel] : '0;
      pg_idx    = page_ok ? page : '0;
      pg_lsb    = LSB_W'(32'(pg_idx) * PAGE_BITS);
      page_word = sel_reg[pg_lsb +: PAGE_BITS];
   end

   // One decoder per displayed digit
   for (genvar d = 0; d < DIGITS; d++) begin : g_dec
      seg7_decode u_dec (
         .hex   (page_word[4*d +: 4]),
         .seg_n (dec_seg[d])
      );
   end

   // Display image: blank everything on a bad page, blank the cursor digit
   // during the high blink phase
   always_comb begin
      for (int d = 0; d < DIGITS; d++) begin
         if (!page_ok) begin
            seg_n_d[d] = SEG_BLANK;
         end else if (blink_q[BLINK_W-1] && (cursor_q == CUR_W'(d))) begin
            seg_n_d[d] = SEG_BLANK;
         end else begin
            seg_n_d[d] = dec_seg[d];
         end
      end
      cursor_led_d = DIGITS'(1) << cursor_q;
   end

   // All state flops with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q         <= 3'b111;
         s2_q         <= 3'b111;
         s3_q         <= 3'b111;
         vld_q        <= '0;
         arm_q        <= '0;
         cursor_q     <= '0;
         regs_q       <= '0;
         blink_q      <= '0;
         wr_pulse_q   <= 1'b0;
         seg_n_q      <= {DIGITS{SEG_ZERO}};
         cursor_led_q <= DIGITS'(1);
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         vld_q        <= vld_d;
         arm_q        <= arm_d;
         cursor_q     <= cursor_d;
         regs_q       <= regs_d;
         blink_q      <= blink_d;
         wr_pulse_q   <= wr_pulse_d;
         seg_n_q      <= seg_n_d;
         cursor_led_q <= cursor_led_d;
      end
   end

   assign regs_out   = regs_q;
   assign seg_n      = seg_n_q;
   assign cursor_led = cursor_led_q;
   assign wr_pulse   = wr_pulse_q;

endmodule

// File: tb/tb_hex_entry_bank.sv
// Directed bench for hex_entry_bank: table of button operations with
// expected registers/cursor, plus hand sequences for blink, load/set
// collisions and reset during a held press.
module tb_hex_entry_bank;

   localparam int DATA_W   = 128;
   localparam int DIGITS   = 8;
   localparam int NUM_REGS = 2;
   localparam int BLINK_W  = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    btn_n = 3'b111;
   logic [3:0]    nibble_in = 4'h0;
   logic          reg_sel = 1'b0;
   logic [1:0]    page = 2'd0;
   logic          ld_valid = 1'b0;
   logic          ld_sel = 1'b0;
   logic [127:0]  ld_data = '0;
   logic [255:0]  regs_out;
   logic [55:0]   seg_n;
   logic [7:0]    cursor_led;
   logic          wr_pulse;

   int checks = 0;
   int errors = 0;

   logic [BLINK_W-1:0] bcnt;
   logic [BLINK_W-1:0] bprev;

   hex_entry_bank #(
      .DATA_W   (DATA_W),
      .DIGITS   (DIGITS),
      .NUM_REGS (NUM_REGS),
      .BLINK_W  (BLINK_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (btn_n),
      .nibble_in  (nibble_in),
      .reg_sel    (reg_sel),
      .page       (page),
      .ld_valid   (ld_valid),
      .ld_sel     (ld_sel),
      .ld_data    (ld_data),
      .regs_out   (regs_out),
      .seg_n      (seg_n),
      .cursor_led (cursor_led),
      .wr_pulse   (wr_pulse)
   );

   always #5 clk = ~clk;

   // Independent blink phase: bprev is the counter value the display saw
   always @(posedge clk) begin
      if (reset) bcnt <= '0;
      else       bcnt <= bcnt + 1'b1;
      bprev <= bcnt;
   end

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Press buttons in mask for 3 cycles, release, and count wr_pulse cycles
   task automatic press(input logic [2:0] m, output int nwr);
      nwr = 0;
      btn_n = ~m;
      repeat (3) begin @(negedge clk); if (wr_pulse) nwr++; end
      btn_n = 3'b111;
      repeat (5) begin @(negedge clk); if (wr_pulse) nwr++; end
   endtask

   // Same as press, with ld_valid placed on the edge where the push lands
   task automatic press_ld(input logic [2:0] m, output int nwr);
      nwr = 0;
      btn_n = ~m;
      @(negedge clk);
      @(negedge clk);
      ld_valid = 1'b1;
      @(negedge clk); if (wr_pulse) nwr++;
      ld_valid = 1'b0;
      btn_n = 3'b111;
      repeat (5) begin @(negedge clk); if (wr_pulse) nwr++; end
   endtask

   typedef struct {
      logic [2:0]   push;
      logic [3:0]   nib;
      logic         sel;
      logic [1:0]   pg;
      logic [255:0] regs;
      logic [7:0]   led;
      int           wr;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] p, input logic [3:0] n, input logic s,
                               input logic [1:0] g, input logic [127:0] r1, input logic [127:0] r0,
                               input logic [7:0] l, input int w);
      vec_t v;
      v.push = p; v.nib = n; v.sel = s; v.pg = g;
      v.regs = {r1, r0}; v.led = l; v.wr = w;
      return v;
   endfunction

   localparam logic [127:0] R1A = 128'hA << 116;
   localparam logic [127:0] R0A = 128'h7 << 20;
   localparam logic [127:0] R0B = (128'h7 << 20) | (128'h3 << 52);
   localparam logic [127:0] LD0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] LD1 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

   vec_t vecs[15];

   initial begin
      int nwr;
      logic [55:0] exp_seg;

      // push mask: [0] left, [1] right, [2] set
      vecs[0]  = mk(3'b010, 4'h0, 1'b0, 2'd0, '0, '0, 8'h80, 0);
      vecs[1]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h01, 0);
      vecs[2]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h02, 0);
      vecs[3]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h04, 0);
      vecs[4]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h08, 0);
      vecs[5]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h10, 0);
      vecs[6]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h20, 0);
      vecs[7]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h40, 0);
      vecs[8]  = mk(3'b001, 4'h0, 1'b0, 2'd0, '0, '0, 8'h80, 0);
      vecs[9]  = mk(3'b010, 4'h0, 1'b0, 2'd0, '0, '0, 8'h40, 0);
      vecs[10] = mk(3'b010, 4'h0, 1'b0, 2'd0, '0, '0, 8'h20, 0);
      vecs[11] = mk(3'b100, 4'hA, 1'b1, 2'd3, R1A, '0, 8'h20, 1);
      vecs[12] = mk(3'b011, 4'h0, 1'b0, 2'd0, R1A, '0, 8'h20, 0);
      vecs[13] = mk(3'b101, 4'h7, 1'b0, 2'd0, R1A, R0A, 8'h20, 1);
      vecs[14] = mk(3'b110, 4'h3, 1'b0, 2'd1, R1A, R0B, 8'h20, 1);

      // Reset and idle state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_regs", regs_out, '0);
      check("rst_seg", 256'(seg_n), 256'({8{7'h40}}));
      check("rst_led", 256'(cursor_led), 256'(8'h01));
      check("rst_wr", 256'(wr_pulse), '0);
      repeat (5) @(negedge clk);

      // Table-driven button operations
      for (int i = 0; i < 15; i++) begin
         reg_sel   = vecs[i].sel;
         page      = vecs[i].pg;
         nibble_in = vecs[i].nib;
         press(vecs[i].push, nwr);
         check($sformatf("vec%0d_regs", i), regs_out, vecs[i].regs);
         check($sformatf("vec%0d_led", i), 256'(cursor_led), 256'(vecs[i].led));
         check($sformatf("vec%0d_wr", i), 256'(nwr), 256'(vecs[i].wr));
      end

      // Display of reg1 page 3 with cursor on digit 5 across both blink phases
      reg_sel = 1'b1;
      page    = 2'd3;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 70; c++) begin
         for (int d = 0; d < 8; d++) exp_seg[7*d +: 7] = 7'h40;
         exp_seg[35 +: 7] = bprev[BLINK_W-1] ? 7'h7F : 7'h08;
         check($sformatf("blink_seg_c%0d", c), 256'(seg_n), 256'(exp_seg));
         @(negedge clk);
      end

      // Load and set to the same register: load wins
      reg_sel = 1'b0; page = 2'd0; nibble_in = 4'h5;
      ld_sel = 1'b0; ld_data = LD0;
      press_ld(3'b100, nwr);
      check("coll_same_regs", regs_out, {R1A, LD0});
      check("coll_same_wr", 256'(nwr), 256'(1));

      // Load and set to different registers: both land
      reg_sel = 1'b1; page = 2'd0; nibble_in = 4'hC;
      ld_sel = 1'b0; ld_data = LD1;
      press_ld(3'b100, nwr);
      check("coll_diff_regs", regs_out, {R1A | (128'hC << 20), LD1});
      check("coll_diff_wr", 256'(nwr), 256'(1));

      // Reset while set is held and a load is requested
      reg_sel = 1'b0; page = 2'd0; nibble_in = 4'hF;
      btn_n = 3'b011;
      repeat (2) @(negedge clk);
      reset = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_data = LD0;
      repeat (2) @(negedge clk);
      reset = 1'b0; ld_valid = 1'b0;
      check("rst_ld_regs", regs_out, '0);
      check("rst_ld_led", 256'(cursor_led), 256'(8'h01));
      nwr = 0;
      repeat (20) begin @(negedge clk); if (wr_pulse) nwr++; end
      check("held_no_wr", 256'(nwr), '0);
      check("held_regs", regs_out, '0);
      btn_n = 3'b111;
      repeat (5) @(negedge clk);

      // Fresh press: write lands exactly two edges after sampling
      btn_n = 3'b011;
      @(negedge clk);
      check("lat_k", regs_out, '0);
      @(negedge clk);
      check("lat_k1", regs_out, '0);
      @(negedge clk);
      check("lat_k2_regs", regs_out, {128'h0, 128'hF});
      check("lat_k2_wr", 256'(wr_pulse), 256'(1));
      btn_n = 3'b111;
      nwr = 0;
      repeat (6) begin @(negedge clk); if (wr_pulse) nwr++; end
      check("post_no_wr", 256'(nwr), '0);
      check("post_regs", regs_out, {128'h0, 128'hF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_entry_bank.md
# hex_entry_bank

Parametrised keypad-style hex entry and display block for the crypto demo board. The operator uses three push-buttons and a 4-bit switch field to edit, nibble by nibble, any of NUM_REGS wide registers (plaintext, key, ...). Each register is split into pages of DIGITS hex digits and shown on active-low 7-segment displays, with the edit cursor blinking. The cipher core can overwrite a whole register through a load port, and all registers are exported flat to the core.

## Interface
- DATA_W, 128, width of each register in bits; must be a multiple of 4*DIGITS
- DIGITS, 8, displayed digits per page (one page = 4*DIGITS bits)
- NUM_REGS, 2, number of editable registers (channels)
- BLINK_W, 24, blink counter width; blink phase = counter MSB
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- btn_n  in  3  raw active-low buttons: [0] cursor left (+1), [1] cursor right (−1), [2] set
- nibble_in  in  4  value written at cursor on set
- reg_sel  in  max(1,$clog2(NUM_REGS))  register being edited/displayed
- page  in  $clog2(DATA_W/(4*DIGITS))  page of selected register being edited/displayed
- ld_valid  in  1  core load request, single-cycle qualifier
- ld_sel  in  max(1,$clog2(NUM_REGS))  register targeted by load
- ld_data  in  DATA_W  load value
- regs_out  out  NUM_REGS*DATA_W  all registers, register r at [r*DATA_W +: DATA_W]
- seg_n  out  7*DIGITS  active-low segments, digit d at [7d +: 7], bit order gfedcba
- cursor_led  out  DIGITS  one-hot cursor position
- wr_pulse  out  1  one-cycle strobe, high the cycle after any register write

## Operation
- Button path: btn_n → two-flop synchroniser s1, s2 → history flop s3; push = s3 & ~s2, i.e. a falling edge, one cycle per press. No debounce; bounce yields extra pushes.
- Cursor: 0..DIGITS−1, 0 = rightmost (least significant) digit. Left push = +1, right push = −1, modulo DIGITS (wraps both ways). The cursor is retained across page/reg_sel changes.
- Simultaneous pushes:
  - set with any move: set executes, cursor holds.
  - left+right without set: no action.
- Set: nibble index = page*DIGITS + cursor. Writes bits [4*idx +: 4] of register reg_sel with nibble_in. All other bits are unchanged.
- Load: on ld_valid, register ld_sel ← ld_data.
- Collisions:
  - Load and set in the same cycle to the same register: load wins, set is dropped.
  - Load and set to different registers: both are applied.
- Out-of-range page (page ≥ DATA_W/(4*DIGITS)): set is ignored and all digits are blanked (7'h7F).
- Display: digit d shows nibble page*DIGITS+d of register reg_sel through the seg7 decode. While the blink MSB = 1, the cursor digit is blanked (7'h7F).
- Blink counter: free-running and wraps.
- wr_pulse: asserted the cycle after a set or load is applied.

## Timing
- Reset values:
  - registers 0
  - cursor 0, cursor_led = 1
  - s1/s2/s3 = 1 (released)
  - blink counter 0
  - wr_pulse 0
  - seg_n = 7'h40 ("0") on every digit
- Button latency: btn_n sampled low at edge k gives push during cycle k+1..k+2. The register or cursor updates at edge k+2.
- Register updates at the clock edge where ld_valid or push is high. regs_out is a direct register output.
- seg_n and cursor_led are registered: they reflect register, cursor, page, reg_sel and blink state one cycle after the change.
- Reset mid-press: the synchroniser is reloaded to "released". A button still held after reset generates no push until it is released and pressed again.
- Reset with ld_valid high: reset wins.

## Structure
- Package hex_entry_pkg:
  - button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_SET=2
  - SEG_BLANK=7'h7F
  - 16-entry active-low segment constant array
- Sub-module seg7_decode: 4-bit hex → 7-bit active-low segments, purely combinational, instanced DIGITS times.
- Top owns:
  - synchroniser and edge detect
  - cursor counter
  - register array
  - write arbitration
  - blink counter
  - output registers

## Test plan
- Reset, then idle: regs_out = 0, seg_n all 7'h40 (blink MSB 0), cursor_led = 8'h01, wr_pulse 0.
- Cursor wrap (DIGITS=8, page=0): one right push → cursor_led 8'h80. Then 8 left pushes → 8'h80 again, with every step shifting the one-hot left by one.
- Nibble write: reg_sel=1, page=3, cursor=5, nibble_in=4'hA, set push → reg1[4*29 +: 4]=4'hA, all other bits 0, wr_pulse high for one cycle. Digit 5 shows 7'h08 (A) when the blink MSB is 0 and 7'h7F when it is 1.
- Collision: ld_valid with ld_sel=0, ld_data=128'h0123…CDEF in the same cycle as set on reg_sel=0 → reg0 equals ld_data exactly. Repeat with reg_sel=1 → both registers are updated.
- Simultaneous left+right push → cursor unchanged. Left+set → write at the old cursor, cursor unchanged.
- Reset asserted while btn_n[2] is held low for 20 cycles after reset → no write. Release and press again → exactly one write, landing 2 edges after the press is sampled.
